quotient_bcd_encoder: RTL and testbench



---
 rtl/quotient_bcd_encoder.sv | 134 +++++++++++++
 tb/tb_quotient_bcd_encoder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/quotient_bcd_encoder.sv
// Serial quotient to excess-3 decimal encoder.
// Double-dabble conversion, MSD-first digit stream with range flag.
module quotient_bcd_encoder #(
  parameter int QW = 10,
  parameter int ND = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic       out_err
);

  localparam int BW = 4 * ND;
  localparam int CW = $clog2(QW + 1);
  localparam int OW = $clog2(ND + 1);
  localparam int unsigned MAXV = 10 ** ND;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IN,
    S_CONV,
    S_OUT
  } state_t;

  state_t          state;
  logic [QW-1:0]   sh_q;
  logic [BW-1:0]   bcd_q;
  logic [CW-1:0]   cnt;
  logic [OW-1:0]   out_cnt;
  logic            err_q;

  logic [BW-1:0]    bcd_adj;
  logic [BW+QW-1:0] dd_cat;
  logic [3:0]       digit;
  logic             over;

  // Add-3 correction on every BCD nibble that would overflow on doubling
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // One double-dabble step; the bit leaving the BCD MSB is dropped
  assign dd_cat = {bcd_adj, sh_q} << 1;

  // Range flag taken from the raw binary quotient
  assign over = (32'(sh_q) >= 32'(MAXV));

  // Select the digit being emitted, most significant first
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < ND; i++) begin
      if (out_cnt == OW'(i))
        digit = bcd_q[4*(ND-1-i) +: 4];
    end
  end

  // Frame capture, conversion and output sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sh_q      <= '0;
      bcd_q     <= '0;
      cnt       <= '0;
      out_cnt   <= '0;
      err_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 4'd0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_data  <= 4'd0;
      out_err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            sh_q    <= QW'(in_data);
            bcd_q   <= '0;
            err_q   <= 1'b0;
            cnt     <= CW'(1);
            out_cnt <= '0;
            state   <= S_IN;
          end
        end
        S_IN: begin
          if (in_valid) begin
            sh_q <= {sh_q[QW-2:0], in_data};
            if (cnt == CW'(QW - 1)) begin
              cnt   <= '0;
              state <= S_CONV;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            sh_q  <= '0;
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        S_CONV: begin
          if (cnt == '0)
            err_q <= over;
          {bcd_q, sh_q} <= dd_cat;
          if (cnt == CW'(QW - 1)) begin
            cnt     <= '0;
            out_cnt <= '0;
            state   <= S_OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_OUT: begin
          if (out_cnt == OW'(ND)) begin
            out_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
            out_err   <= err_q;
            out_data  <= err_q ? 4'd0 : digit + 4'd3;
            out_cnt   <= out_cnt + OW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quotient_bcd_encoder.sv
// Directed bench for quotient_bcd_encoder.
// Hand-computed excess-3 codes per frame.
module tb_quotient_bcd_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_data;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  quotient_bcd_encoder #(.QW(10), .ND(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic send_bits(input logic [9:0] q, input int nb);
    for (int i = 9; i > 9 - nb; i--) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = q[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 1'b0;
  endtask

  task automatic quiet(input string tag, input int cyc);
    int seen;
    seen = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic frame(input string tag, input logic [9:0] q,
                       input logic [11:0] codes, input bit err,
                       input bit pulse);
    int lat;
    logic [11:0] c;
    lat = 0;
    c = codes;
    send_bits(q, 10);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      in_valid = pulse && lat <= 10;
      in_data  = pulse;
    end
    in_valid = 1'b0;
    in_data  = 1'b0;
    check({tag, "_lat"}, lat, 11);
    for (int d = 0; d < 3; d++) begin
      if (d > 0) @(negedge clk);
      check($sformatf("%s_v%0d", tag, d), int'(out_valid), 1);
      check($sformatf("%s_d%0d", tag, d), int'(out_data),
            int'(c[11-4*d -: 4]));
      check($sformatf("%s_e%0d", tag, d), int'(out_err), int'(err));
    end
    @(negedge clk);
    check({tag, "_vend"}, int'(out_valid), 0);
    check({tag, "_dend"}, int'(out_data), 0);
    check({tag, "_eend"}, int'(out_err), 0);
    quiet({tag, "_idle"}, pulse ? 30 : 3);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_v", int'(out_valid), 0);
    check("rst_d", int'(out_data), 0);
    check("rst_e", int'(out_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    frame("q123", 10'd123, 12'b0100_0101_0110, 1'b0, 1'b0);
    frame("q0", 10'd0, 12'b0011_0011_0011, 1'b0, 1'b0);
    frame("q999", 10'd999, 12'b1100_1100_1100, 1'b0, 1'b0);
    frame("q1023", 10'd1023, 12'b0000_0000_0000, 1'b1, 1'b0);
    frame("q1000", 10'd1000, 12'b0000_0000_0000, 1'b1, 1'b0);

    send_bits(10'b1011011011, 5);
    quiet("abort", 25);
    frame("q7", 10'd7, 12'b0011_0011_1010, 1'b0, 1'b0);

    frame("q42p", 10'd42, 12'b0011_0111_0101, 1'b0, 1'b1);

    send_bits(10'd999, 10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_v", int'(out_valid), 0);
    check("mid_rst_d", int'(out_data), 0);
    check("mid_rst_e", int'(out_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet("after_rst", 30);
    frame("q500", 10'd500, 12'b1000_0011_0011, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
